fpu_add_align: RTL and testbench
================================

# fpu_add_align

Sequential operand-alignment front end for the FPU add/sub pipeline. Accepts two IEEE-754 single-precision operands and the function mode over a valid/ready handshake, then:
- unpacks both operands and orders them by magnitude;
- right-shifts the smaller fraction by the exponent difference, a programmable number of bits per cycle, accumulating a sticky bit.

It presents the common exponent and both aligned 26-bit fractions to the adder stage. Its outputs are the exponent, fraction and ordering inputs that the final rounding/normalisation stage consumes.

## Interface
- SHIFT_PER_CYCLE, 4, bits of right shift applied per ALIGN cycle (1..26)
- MAX_SHIFT, 26, exponent difference at or above which the small fraction collapses entirely into sticky
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands this cycle
- floating_point1  in  32  operand A
- floating_point2  in  32  operand B
- function_mode  in  7  ADD=7'b0100000, SUB=7'b0100100; other codes treated as ADD
- out_valid  out  1  aligned result held
- out_ready  in  1  downstream accepts result
- exponent_max  out  8  larger effective exponent
- frac_large  out  26  larger operand: [25] hidden, [24:2] mantissa, [1] guard, [0] sticky
- frac_small  out  26  smaller operand aligned to exponent_max, same layout
- sign_large  out  1  sign of larger-magnitude operand
- sign_small  out  1  sign of smaller operand; already inverted for SUB when it is operand B
- cmp_out  out  1  1 when |B| > |A| (operands swapped)
- inv  out  1  either operand NaN, or inf − inf under effective subtraction

## Operation
- FSM states: IDLE, ALIGN, DONE.
- IDLE, on in_valid & in_ready, performs unpack:
  - Exponent 0 gives hidden bit 0 and effective exponent 1. Otherwise hidden bit is 1.
  - For SUB, operand B sign is inverted before ordering.
  - Ordering compares {exp, mantissa}. On a tie, A is large and cmp_out=0.
  - diff = exp_large − exp_small, clamped to MAX_SHIFT. Registers a remaining-shift counter.
  - Next state is DONE if diff==0, else ALIGN.
- ALIGN, each cycle:
  - step = min(remaining, SHIFT_PER_CYCLE).
  - frac_small >>= step. The OR of all bits shifted out, plus the old bit 0, goes into bit 0.
  - remaining −= step.
  - Go to DONE when remaining reaches 0.
- DONE: out_valid=1; all outputs stable until out_ready.
  - out_ready=1 with no new accept: go to IDLE.
  - out_ready=1 with in_valid=1 in the same cycle: accept the new operands and unpack in that cycle (back-to-back).
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Special operands (exponent 0xFF):
  - No shifting; go directly to DONE.
  - inv set per the definition above.
  - exponent_max=0xFF.
  - Fractions pass through unpacked.
- Shift of MAX_SHIFT or more: frac_small = {25'b0, |original}.
- rst in any state:
  - state=IDLE; in-flight operation discarded.
  - out_valid=0, inv=0, cmp_out=0, every data output 0.
  - in_ready=1 the cycle after reset is deasserted.

## Timing
- Latency from accept edge to out_valid=1: 1 + ceil(min(diff,MAX_SHIFT)/SHIFT_PER_CYCLE) cycles. Special operands take 1 cycle.
- Throughput: one result per (latency) cycles, with zero bubble when out_ready is held high.
- out_valid stalls indefinitely without corruption while out_ready=0. in_ready=0 throughout ALIGN.
- All outputs are registered; no combinational path from in_* to out_*. in_ready depends combinationally on out_ready in DONE only.

## Structure
- Shared package fpu_add_pkg:
  - function-mode localparams ADD/SUB;
  - FSM state enum;
  - fraction-layout widths (FRAC_W=26, EXP_W=8);
  - a packed unpacked-operand struct {sign, exp, frac26}.
- One sub-module: fpu_sticky_shift. Combinational: frac, step in; shifted frac with sticky folded into bit 0 out. Reused by every ALIGN cycle.

## Test plan
- 0x3F800000 + 0x3F800000, ADD → out_valid 1 cycle after accept; exponent_max=0x7F, frac_large=frac_small=26'h2000000, cmp_out=0, inv=0.
- 0x3F800000 + 0x3E800000 (diff 2), SPC=4 → 2-cycle latency; frac_small=26'h0800000, sticky 0.
- 0x3F800000 + 0x4F800000 (diff 32) → cmp_out=1, exponent_max=0x9F, frac_small=26'h0000001, latency 8 cycles.
- 0x7F800000 SUB 0x7F800000 → inv=1, exponent_max=0xFF, latency 1. Also 0x7FC00000 ADD 0x3F800000 → inv=1.
- out_ready held low 5 cycles after out_valid → outputs constant, in_ready=0. Then out_ready=1 with in_valid=1 → new operands accepted that same cycle.
- rst asserted mid-ALIGN (diff 20) → next cycle state IDLE, out_valid=0, in_ready=1. The next transaction produces the correct result.

Source files
------------

// File: rtl/fpu_add_pkg.sv
// Shared types and helpers for the FPU add/sub front end: function codes,
// fraction layout, FSM states and the unpacked-operand record.
package fpu_add_pkg;

  localparam int FRAC_W  = 26;
  localparam int EXP_W   = 8;
  localparam int SHIFT_W = 5;

  localparam logic [6:0]       FN_ADD      = 7'b0100000;
  localparam logic [6:0]       FN_SUB      = 7'b0100100;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } operand_t;

  // Denormals read as exponent 1 with a zero hidden bit.
  function automatic operand_t unpack_op(input logic [31:0] fp);
    operand_t op;
    op.sign = fp[31];
    op.exp  = (fp[30:23] == 8'h00) ? 8'h01 : fp[30:23];
    op.frac = {(fp[30:23] != 8'h00), fp[22:0], 2'b00};
    return op;
  endfunction

  function automatic logic is_nan(input logic [31:0] fp);
    return (fp[30:23] == EXP_SPECIAL) && (fp[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] fp);
    return (fp[30:23] == EXP_SPECIAL) && (fp[22:0] == 23'd0);
  endfunction

endpackage

// File: rtl/fpu_sticky_shift.sv
// Combinational right shift of an aligned fraction; every bit shifted out is
// OR-folded into bit 0 so rounding still sees the lost precision.
module fpu_sticky_shift
  import fpu_add_pkg::*;
(
  input  logic [FRAC_W-1:0]  frac_i,
  input  logic [SHIFT_W-1:0] step_i,
  output logic [FRAC_W-1:0]  frac_o
);

  logic [FRAC_W-1:0] mask_s;
  logic [FRAC_W-1:0] shifted_s;
  logic              sticky_s;

  always_comb begin
    mask_s    = (FRAC_W'(1) << step_i) - FRAC_W'(1);
    shifted_s = frac_i >> step_i;
    sticky_s  = |(frac_i & mask_s);
    frac_o    = {shifted_s[FRAC_W-1:1], shifted_s[0] | sticky_s};
  end

endmodule

// File: rtl/fpu_add_align.sv
// Operand-alignment front end: unpacks and orders two singles, then shifts the
// smaller fraction a few bits per cycle until it sits on the larger exponent.
module fpu_add_align
  import fpu_add_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = 4,
  parameter int MAX_SHIFT       = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       floating_point1,
  input  logic [31:0]       floating_point2,
  input  logic [6:0]        function_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exponent_max,
  output logic [FRAC_W-1:0] frac_large,
  output logic [FRAC_W-1:0] frac_small,
  output logic              sign_large,
  output logic              sign_small,
  output logic              cmp_out,
  output logic              inv
);

  localparam logic [SHIFT_W-1:0] SPC_C       = SHIFT_W'(SHIFT_PER_CYCLE);
  localparam logic [EXP_W-1:0]   MAX_SHIFT_C = EXP_W'(MAX_SHIFT);

  state_e             state_q, state_d;
  logic [SHIFT_W-1:0] rem_q, rem_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [FRAC_W-1:0]  fl_q, fl_d, fs_q, fs_d;
  logic               sl_q, sl_d, ss_q, ss_d;
  logic               cmp_q, cmp_d, inv_q, inv_d;
  logic               ov_q;

  operand_t           op_a_s, op_b_s, op_l_s, op_s_s;
  logic               is_sub_s, swap_s, special_s, inv_s, accept_s, load_s;
  logic [EXP_W-1:0]   diff_s;
  logic [SHIFT_W-1:0] ld_rem_s, step_s;
  logic [FRAC_W-1:0]  shifted_s;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept_s  = in_valid & in_ready;

  // Unpack, sign-adjust for SUB, order by magnitude and size the shift.
  always_comb begin
    is_sub_s    = (function_mode == FN_SUB);
    op_a_s      = unpack_op(floating_point1);
    op_b_s      = unpack_op(floating_point2);
    op_b_s.sign = floating_point2[31] ^ is_sub_s;
    swap_s      = floating_point2[30:0] > floating_point1[30:0];
    op_l_s      = swap_s ? op_b_s : op_a_s;
    op_s_s      = swap_s ? op_a_s : op_b_s;
    special_s   = (floating_point1[30:23] == EXP_SPECIAL) |
                  (floating_point2[30:23] == EXP_SPECIAL);
    inv_s       = is_nan(floating_point1) | is_nan(floating_point2) |
                  (is_inf(floating_point1) & is_inf(floating_point2) &
                   (op_a_s.sign != op_b_s.sign));
    diff_s      = op_l_s.exp - op_s_s.exp;
    if (special_s) begin
      ld_rem_s = {SHIFT_W{1'b0}};
    end else if (diff_s >= MAX_SHIFT_C) begin
      ld_rem_s = SHIFT_W'(MAX_SHIFT);
    end else begin
      ld_rem_s = diff_s[SHIFT_W-1:0];
    end
  end

  // Per-cycle shift amount for the ALIGN loop.
  always_comb begin
    if (rem_q > SPC_C) begin
      step_s = SPC_C;
    end else begin
      step_s = rem_q;
    end
  end

  fpu_sticky_shift u_sticky_shift (
    .frac_i (fs_q),
    .step_i (step_s),
    .frac_o (shifted_s)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    exp_d   = exp_q;
    fl_d    = fl_q;
    fs_d    = fs_q;
    sl_d    = sl_q;
    ss_d    = ss_q;
    cmp_d   = cmp_q;
    inv_d   = inv_q;
    load_s  = 1'b0;
    case (state_q)
      IDLE: begin
        load_s = accept_s;
      end
      ALIGN: begin
        fs_d = shifted_s;
        rem_d = rem_q - step_s;
        if (rem_d == {SHIFT_W{1'b0}}) begin
          state_d = DONE;
        end else begin
          state_d = ALIGN;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            load_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Back-to-back accepts in DONE share the IDLE load path.
    if (load_s) begin
      exp_d   = special_s ? EXP_SPECIAL : op_l_s.exp;
      fl_d    = op_l_s.frac;
      fs_d    = op_s_s.frac;
      sl_d    = op_l_s.sign;
      ss_d    = op_s_s.sign;
      cmp_d   = swap_s;
      inv_d   = inv_s;
      rem_d   = ld_rem_s;
      state_d = (ld_rem_s == {SHIFT_W{1'b0}}) ? DONE : ALIGN;
    end else begin
      load_s = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= {SHIFT_W{1'b0}};
      exp_q   <= {EXP_W{1'b0}};
      fl_q    <= {FRAC_W{1'b0}};
      fs_q    <= {FRAC_W{1'b0}};
      sl_q    <= 1'b0;
      ss_q    <= 1'b0;
      cmp_q   <= 1'b0;
      inv_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      exp_q   <= exp_d;
      fl_q    <= fl_d;
      fs_q    <= fs_d;
      sl_q    <= sl_d;
      ss_q    <= ss_d;
      cmp_q   <= cmp_d;
      inv_q   <= inv_d;
      ov_q    <= (state_d == DONE);
    end
  end

  assign out_valid    = ov_q;
  assign exponent_max = exp_q;
  assign frac_large   = fl_q;
  assign frac_small   = fs_q;
  assign sign_large   = sl_q;
  assign sign_small   = ss_q;
  assign cmp_out      = cmp_q;
  assign inv          = inv_q;

endmodule

// File: tb/tb_fpu_add_align.sv
// Bench for fpu_add_align: directed vector table, stall/back-to-back and
// mid-ALIGN reset sequences, then random operands against a reference model.
module tb_fpu_add_align;

  localparam int SPC = 4;
  localparam logic [6:0] M_ADD = 7'b0100000;
  localparam logic [6:0] M_SUB = 7'b0100100;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  m;
    logic [7:0]  e;
    logic [25:0] fl;
    logic [25:0] fs;
    logic        sl;
    logic        ss;
    logic        cmp;
    logic        inv;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] fp1 = 32'd0;
  logic [31:0] fp2 = 32'd0;
  logic [6:0]  mode = 7'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  exponent_max;
  logic [25:0] frac_large;
  logic [25:0] frac_small;
  logic        sign_large;
  logic        sign_small;
  logic        cmp_out;
  logic        inv;

  int n_vec  = 0;
  int n_miss = 0;

  fpu_add_align #(.SHIFT_PER_CYCLE(SPC), .MAX_SHIFT(26)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .floating_point1 (fp1),
    .floating_point2 (fp2),
    .function_mode   (mode),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .exponent_max    (exponent_max),
    .frac_large      (frac_large),
    .frac_small      (frac_small),
    .sign_large      (sign_large),
    .sign_small      (sign_small),
    .cmp_out         (cmp_out),
    .inv             (inv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".exponent_max"}, 32'(exponent_max), 32'(v.e));
    chk({tag, ".frac_large"}, 32'(frac_large), 32'(v.fl));
    chk({tag, ".frac_small"}, 32'(frac_small), 32'(v.fs));
    chk({tag, ".sign_large"}, 32'(sign_large), 32'(v.sl));
    chk({tag, ".sign_small"}, 32'(sign_small), 32'(v.ss));
    chk({tag, ".cmp_out"}, 32'(cmp_out), 32'(v.cmp));
    chk({tag, ".inv"}, 32'(inv), 32'(v.inv));
  endtask

  // Reference: whole-shift arithmetic on integer fractions.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic [6:0] m);
    vec_t   r;
    int     ea, eb, eea, eeb, el, es, sh;
    longint fa, fb, fL, fS, res;
    bit     sb, swap, special, nan_a, nan_b, inf_a, inf_b;
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    eea = (ea == 0) ? 1 : ea;
    eeb = (eb == 0) ? 1 : eb;
    fa  = ((ea != 0) ? (longint'(1) << 25) : longint'(0)) + longint'(a[22:0]) * 4;
    fb  = ((eb != 0) ? (longint'(1) << 25) : longint'(0)) + longint'(b[22:0]) * 4;
    sb  = b[31] ^ (m == M_SUB);
    swap = (b[30:0] > a[30:0]);
    special = (ea == 255) || (eb == 255);
    nan_a = (ea == 255) && (a[22:0] != 23'd0);
    nan_b = (eb == 255) && (b[22:0] != 23'd0);
    inf_a = (ea == 255) && (a[22:0] == 23'd0);
    inf_b = (eb == 255) && (b[22:0] == 23'd0);
    el = swap ? eeb : eea;
    es = swap ? eea : eeb;
    fL = swap ? fb : fa;
    fS = swap ? fa : fb;
    sh = special ? 0 : ((el - es > 26) ? 26 : el - es);
    res = fS >> sh;
    if ((fS & ((longint'(1) << sh) - 1)) != 0) res = res | 1;
    r.a   = a;
    r.b   = b;
    r.m   = m;
    r.e   = special ? 8'hFF : 8'(el);
    r.fl  = 26'(fL);
    r.fs  = 26'(res);
    r.sl  = swap ? sb : a[31];
    r.ss  = swap ? a[31] : sb;
    r.cmp = swap;
    r.inv = nan_a | nan_b | (inf_a & inf_b & (a[31] != sb));
    r.lat = special ? 1 : 1 + (sh + SPC - 1) / SPC;
    return r;
  endfunction

  // Latency counts the accept edge as cycle 1.
  task automatic do_op(input vec_t v, output int lat);
    @(negedge clk);
    fp1 = v.a;
    fp2 = v.b;
    mode = v.m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      chk("in_ready_align", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t tbl[10];
  vec_t v;
  int   lat;

  initial begin
    tbl[0] = '{32'h3F800000, 32'h3F800000, M_ADD, 8'h7F, 26'h2000000, 26'h2000000, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[1] = '{32'h3F800000, 32'h3E800000, M_ADD, 8'h7F, 26'h2000000, 26'h0800000, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    tbl[2] = '{32'h3F800000, 32'h4F800000, M_ADD, 8'h9F, 26'h2000000, 26'h0000001, 1'b0, 1'b0, 1'b1, 1'b0, 8};
    tbl[3] = '{32'h7F800000, 32'h7F800000, M_SUB, 8'hFF, 26'h2000000, 26'h2000000, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    tbl[4] = '{32'h7FC00000, 32'h3F800000, M_ADD, 8'hFF, 26'h3000000, 26'h2000000, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[5] = '{32'h3F800000, 32'h40000000, M_SUB, 8'h80, 26'h2000000, 26'h1000000, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    tbl[6] = '{32'h00000001, 32'h00800000, M_ADD, 8'h01, 26'h2000000, 26'h0000004, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[7] = '{32'h3F800000, 32'h3D000001, M_ADD, 8'h7F, 26'h2000000, 26'h0100001, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    tbl[8] = '{32'h3F800000, 32'hBF800000, 7'h33, 8'h7F, 26'h2000000, 26'h2000000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[9] = '{32'h7F800000, 32'hFF800000, M_ADD, 8'hFF, 26'h2000000, 26'h2000000, 1'b0, 1'b1, 1'b0, 1'b1, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.exponent_max", 32'(exponent_max), 32'd0);
    chk("rst.frac_large", 32'(frac_large), 32'd0);
    chk("rst.frac_small", 32'(frac_small), 32'd0);
    chk("rst.cmp_out", 32'(cmp_out), 32'd0);
    chk("rst.inv", 32'(inv), 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i], lat);
      chk($sformatf("tbl%0d.latency", i), 32'(lat), 32'(tbl[i].lat));
      chk_outs($sformatf("tbl%0d", i), tbl[i]);
      release_out();
    end

    // Stall with out_ready low, then back-to-back accept in DONE.
    do_op(tbl[1], lat);
    chk("stall.latency", 32'(lat), 32'(tbl[1].lat));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk_outs("stall", tbl[1]);
      chk("stall.in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    fp1 = tbl[0].a;
    fp2 = tbl[0].b;
    mode = tbl[0].m;
    #1;
    chk("b2b.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk_outs("b2b", tbl[0]);
    release_out();

    // Reset in the middle of a diff-20 alignment.
    @(negedge clk);
    fp1 = 32'h3F800000;
    fp2 = 32'h35800000;
    mode = M_ADD;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("mid.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst.frac_small", 32'(frac_small), 32'd0);
    chk("mid_rst.exponent_max", 32'(exponent_max), 32'd0);
    do_op(tbl[2], lat);
    chk("after_rst.latency", 32'(lat), 32'(tbl[2].lat));
    chk_outs("after_rst", tbl[2]);
    release_out();

    // Random operands against the reference model.
    for (int n = 0; n < 150; n++) begin
      int          ea, eb, off, r;
      logic [31:0] a, b;
      logic [6:0]  m;
      r = int'($urandom_range(0, 19));
      if (r == 0) ea = 255;
      else if (r == 1) ea = 0;
      else ea = int'($urandom_range(1, 254));
      off = int'($urandom_range(0, 40));
      r = int'($urandom_range(0, 19));
      if (r == 0) eb = 255;
      else if (r == 1) eb = 0;
      else if ($urandom_range(0, 1) == 1) eb = (ea + off > 254) ? 254 : ea + off;
      else eb = (ea - off < 0) ? 0 : ea - off;
      a = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      b = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) b[22:0] = 23'd0;
      r = int'($urandom_range(0, 2));
      m = (r == 0) ? M_ADD : ((r == 1) ? M_SUB : 7'($urandom));
      v = model(a, b, m);
      do_op(v, lat);
      chk($sformatf("rnd%0d.latency", n), 32'(lat), 32'(v.lat));
      chk_outs($sformatf("rnd%0d", n), v);
      release_out();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
